// File: rtl/score_tracker.sv
// Hit/score engine: a played note must match the target for HOLD_CYCLES consecutive
// cycles to earn a hit; tracks streak, combo multiplier, saturating score and high score.
module score_tracker #(
    parameter int HOLD_CYCLES = 4,
    parameter int BASE_POINTS = 10,
    parameter int STREAK_STEP = 4,
    parameter int MAX_MULT    = 4,
    parameter int SCORE_W     = 18,
    parameter int STREAK_W    = 8,
    parameter int OCTAVE_FOLD = 1,
    localparam int MULT_W     = $clog2(MAX_MULT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                target_load,
    input  logic [3:0]          target_note,
    input  logic [3:0]          played_note,
    input  logic                clear_score,
    output logic                hit,
    output logic                miss,
    output logic [STREAK_W-1:0] streak,
    output logic [MULT_W-1:0]   multiplier,
    output logic [SCORE_W-1:0]  score,
    output logic [SCORE_W-1:0]  high_score,
    output logic                new_high
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, DONE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          target_q, target_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                hit_q, hit_d, miss_q, miss_d, new_high_q, new_high_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [MULT_W-1:0]   mult_q, mult_d;
    logic [SCORE_W-1:0]  score_q, score_d, high_q, high_d;

    logic                match, hit_now;
    logic [SCORE_W:0]    score_sum;
    logic [SCORE_W-1:0]  score_sat;
    logic [STREAK_W-1:0] streak_inc;
    logic [31:0]         mult_calc;
    logic [MULT_W-1:0]   mult_new;

    // Octave folding lets the low C/D satisfy the high-octave targets 13/14.
    assign match = (target_q != 4'd0) &&
                   ((played_note == target_q) ||
                    ((OCTAVE_FOLD != 0) &&
                     (((target_q == 4'd13) && (played_note == 4'd1)) ||
                      ((target_q == 4'd14) && (played_note == 4'd3)))));

    assign hit_now = (state_q == TRACK) && match && (hold_q == HOLD_W'(HOLD_CYCLES - 1));

    // Score uses the multiplier in force before this hit bumps the streak.
    assign score_sum  = {1'b0, score_q} + (SCORE_W+1)'(BASE_POINTS * int'(mult_q));
    assign score_sat  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign streak_inc = (streak_q == '1) ? streak_q : streak_q + STREAK_W'(1);
    assign mult_calc  = 32'(streak_inc) / 32'(STREAK_STEP) + 32'd1;
    assign mult_new   = (mult_calc > 32'(MAX_MULT)) ? MULT_W'(MAX_MULT) : MULT_W'(mult_calc);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        hold_d     = hold_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        new_high_d = 1'b0;
        streak_d   = streak_q;
        mult_d     = mult_q;
        score_d    = score_q;
        high_d     = high_q;

        if (state_q == TRACK) begin
            hold_d = match ? hold_q + HOLD_W'(1) : '0;
            if (hit_now) begin
                hit_d    = 1'b1;
                score_d  = score_sat;
                streak_d = streak_inc;
                mult_d   = mult_new;
                state_d  = DONE;
            end
        end

        // A load closes the window; only an unfinished TRACK window counts as a miss.
        if (target_load) begin
            target_d = target_note;
            hold_d   = '0;
            state_d  = (target_note != 4'd0) ? TRACK : IDLE;
            if ((state_q == TRACK) && !hit_now) begin
                miss_d   = 1'b1;
                streak_d = '0;
                mult_d   = MULT_W'(1);
            end
        end

        if (clear_score) begin
            score_d  = '0;
            streak_d = '0;
            mult_d   = MULT_W'(1);
        end

        if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            hold_q     <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            new_high_q <= 1'b0;
            streak_q   <= '0;
            mult_q     <= MULT_W'(1);
            score_q    <= '0;
            high_q     <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            hold_q     <= hold_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            new_high_q <= new_high_d;
            streak_q   <= streak_d;
            mult_q     <= mult_d;
            score_q    <= score_d;
            high_q     <= high_d;
        end
    end

    assign hit        = hit_q;
    assign miss       = miss_q;
    assign new_high   = new_high_q;
    assign streak     = streak_q;
    assign multiplier = mult_q;
    assign score      = score_q;
    assign high_score = high_q;
endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: expected hit results are queued when a window is
// driven and compared against the DUT state whenever a hit pulse appears.
module tb_score_tracker;
    localparam int SMAX = (1 << 18) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        target_load = 1'b0;
    logic [3:0]  target_note = 4'd0;
    logic [3:0]  played_note = 4'd0;
    logic        clear_score = 1'b0;
    logic        hit, miss, new_high;
    logic [7:0]  streak;
    logic [2:0]  multiplier;
    logic [17:0] score, high_score;

    score_tracker dut (
        .clk(clk), .reset(reset), .target_load(target_load), .target_note(target_note),
        .played_note(played_note), .clear_score(clear_score), .hit(hit), .miss(miss),
        .streak(streak), .multiplier(multiplier), .score(score), .high_score(high_score),
        .new_high(new_high)
    );

    always #5 clk = ~clk;

    typedef struct {
        int score;
        int streak;
        int mult;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;
    int hit_cnt = 0, miss_cnt = 0, exp_hits = 0;
    int m_score = 0, m_streak = 0, m_mult = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_hit();
        exp_t e;
        m_score  = (m_score + 10 * m_mult > SMAX) ? SMAX : m_score + 10 * m_mult;
        m_streak = (m_streak == 255) ? 255 : m_streak + 1;
        m_mult   = (1 + m_streak / 4 > 4) ? 4 : 1 + m_streak / 4;
        e.score = m_score; e.streak = m_streak; e.mult = m_mult;
        q.push_back(e);
        exp_hits++;
    endtask

    task automatic exp_clear();
        m_score = 0; m_streak = 0; m_mult = 1;
    endtask

    task automatic do_load(input logic [3:0] note);
        target_load = 1'b1;
        target_note = note;
        tick();
        target_load = 1'b0;
    endtask

    // Full window from DONE/IDLE: load, then hold a matching note for 4 cycles.
    task automatic hit_window(input logic [3:0] tgt, input logic [3:0] ply);
        played_note = 4'd0;
        do_load(tgt);
        exp_hit();
        played_note = ply;
        repeat (4) tick();
        chk("window_hit_pulse", 32'(hit), 32'd1);
    endtask

    always @(negedge clk) begin
        if (hit) begin
            hit_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_hit", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_score", 32'(score), 32'(e.score));
                chk("sb_streak", 32'(streak), 32'(e.streak));
                chk("sb_mult", 32'(multiplier), 32'(e.mult));
            end
        end
        if (miss) miss_cnt++;
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_high", 32'(high_score), 32'd0);
        chk("rst_streak", 32'(streak), 32'd0);
        chk("rst_mult", 32'(multiplier), 32'd1);
        chk("rst_pulses", {29'd0, hit, miss, new_high}, 32'd0);
        reset = 1'b1;
        tick();

        // Basic hold: hit on the 4th matching edge, not earlier, never twice
        do_load(4'd5);
        exp_hit();
        played_note = 4'd5;
        repeat (3) tick();
        chk("no_early_hit", 32'(hit), 32'd0);
        tick();
        chk("hit_4th_edge", 32'(hit), 32'd1);
        tick();
        chk("new_high_pulse", 32'(new_high), 32'd1);
        chk("high_10", 32'(high_score), 32'd10);
        repeat (3) tick();
        chk("new_high_once", 32'(new_high), 32'd0);
        chk("single_hit", 32'(hit_cnt), 32'd1);

        // Broken hold restarts the count
        played_note = 4'd0;
        do_load(4'd5);
        exp_hit();
        played_note = 4'd5; repeat (3) tick();
        played_note = 4'd0; tick();
        played_note = 4'd5; repeat (3) tick();
        chk("broken_no_hit", 32'(hit_cnt), 32'd1);
        tick();
        chk("broken_hit", 32'(hit), 32'd1);
        chk("no_miss_done_load", 32'(miss_cnt), 32'd0);

        // Windows 3..8: scores climb 30,40,60,80,100,120
        repeat (6) hit_window(4'd5, 4'd5);
        chk("score_120", 32'(score), 32'd120);
        chk("mult_3", 32'(multiplier), 32'd3);
        chk("streak_8", 32'(streak), 32'd8);

        // clear_score keeps high_score
        clear_score = 1'b1; tick(); clear_score = 1'b0;
        exp_clear();
        tick();
        chk("clr_score", 32'(score), 32'd0);
        chk("clr_streak", 32'(streak), 32'd0);
        chk("clr_mult", 32'(multiplier), 32'd1);
        chk("clr_high_kept", 32'(high_score), 32'd120);

        // Streak 6, then a load mid-window gives a miss
        repeat (6) hit_window(4'd5, 4'd5);
        chk("pre_miss_streak", 32'(streak), 32'd6);
        chk("pre_miss_mult", 32'(multiplier), 32'd2);
        played_note = 4'd0;
        do_load(4'd7);
        repeat (2) tick();
        do_load(4'd0);
        m_streak = 0; m_mult = 1;
        chk("miss_pulse", 32'(miss), 32'd1);
        chk("miss_streak", 32'(streak), 32'd0);
        chk("miss_mult", 32'(multiplier), 32'd1);
        chk("miss_score", 32'(score), 32'd80);
        tick();
        chk("miss_cnt_1", 32'(miss_cnt), 32'd1);

        // Octave folding
        hit_window(4'd13, 4'd1);
        hit_window(4'd14, 4'd3);
        chk("fold_score", 32'(score), 32'd100);

        // Rest window: no scoring either way
        played_note = 4'd0;
        do_load(4'd0);
        played_note = 4'd5; repeat (6) tick();
        played_note = 4'd0;
        do_load(4'd5);
        chk("rest_no_hit", 32'(hit_cnt), 32'(exp_hits));
        chk("rest_no_miss", 32'(miss_cnt), 32'd1);

        // Hit completion coinciding with a load: hit, no miss, new target taken
        exp_hit();
        played_note = 4'd5; repeat (3) tick();
        do_load(4'd6);
        chk("coincide_hit", 32'(hit), 32'd1);
        chk("coincide_no_miss", 32'(miss), 32'd0);
        exp_hit();
        played_note = 4'd6; repeat (4) tick();
        chk("new_target_hit", 32'(hit), 32'd1);
        chk("coincide_miss_cnt", 32'(miss_cnt), 32'd1);

        // Drive score into saturation
        while (m_score < SMAX) hit_window(4'd5, 4'd5);
        chk("sat_score", 32'(score), 32'(SMAX));
        chk("sat_streak", 32'(streak), 32'd255);
        chk("sat_mult", 32'(multiplier), 32'd4);
        hit_window(4'd5, 4'd5);
        chk("sat_hold", 32'(score), 32'(SMAX));
        tick();
        chk("sat_high", 32'(high_score), 32'(SMAX));
        clear_score = 1'b1; tick(); clear_score = 1'b0;
        exp_clear();
        chk("sat_clr_score", 32'(score), 32'd0);
        chk("sat_clr_high", 32'(high_score), 32'(SMAX));

        // Asynchronous reset mid-window
        played_note = 4'd0;
        do_load(4'd5);
        played_note = 4'd5; repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("async_score", 32'(score), 32'd0);
        chk("async_high", 32'(high_score), 32'd0);
        chk("async_mult", 32'(multiplier), 32'd1);
        chk("async_pulses", {29'd0, hit, miss, new_high}, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        played_note = 4'd0;
        repeat (6) tick();
        chk("async_no_miss", 32'(miss_cnt), 32'd1);
        chk("final_hits", 32'(hit_cnt), 32'(exp_hits));
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
